// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, drives the instruction memory address,
// and buffers fetched words with their PCs in a 2-entry queue that feeds decode.
module fetch_sequencer #(
    parameter int unsigned N        = 32,
    parameter int unsigned R        = 6,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         fetch_en,
    output logic [R-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [N-1:0] dec_instr,
    output logic [N-1:0] dec_pc,
    output logic [1:0]   q_count
);

    localparam logic [N-1:0] PC_STEP          = N'(4);
    localparam logic [N-1:0] PC_LOW_MASK      = N'(3);
    localparam logic [N-1:0] RESET_PC_ALIGNED = RESET_PC & ~PC_LOW_MASK;
    localparam logic [1:0]   Q_DEPTH          = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] pc_f;
    logic [N-1:0] pc_next;
    logic [1:0]   count_next;
    logic         push;
    logic         pop;

    logic [N-1:0] q_pc    [2];
    logic [N-1:0] q_instr [2];
    logic         head;
    logic         tail;

    // Memory address and decode view come straight from registered state
    assign imem_addr = pc_f[R+1:2];
    assign dec_valid = (q_count != 2'd0);
    assign dec_instr = q_instr[head];
    assign dec_pc    = q_pc[head];
    assign pop       = dec_valid & dec_ready;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, push decision, next PC and next occupancy
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pc_next    = pc_f;
        count_next = q_count;

        if ((state != ST_IDLE) && fetch_en && !redirect_valid &&
            ((q_count < Q_DEPTH) || pop)) begin
            push = 1'b1;
        end

        if (redirect_valid) begin
            pc_next    = redirect_pc & ~PC_LOW_MASK;
            count_next = 2'd0;
            state_next = fetch_en ? ST_RUN : ST_IDLE;
        end else begin
            if (push) begin
                pc_next = pc_f + PC_STEP;
            end
            case ({push, pop})
                2'b10:   count_next = q_count + 2'd1;
                2'b01:   count_next = q_count - 2'd1;
                default: count_next = q_count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!fetch_en) begin
                        state_next = ST_IDLE;
                    end else if ((count_next == Q_DEPTH) && !pop) begin
                        state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!fetch_en) begin
                        state_next = ST_IDLE;
                    end else if (pop) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // PC, occupancy and queue pointers; a redirect flushes by rewinding both pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f    <= RESET_PC_ALIGNED;
            q_count <= 2'd0;
            head    <= 1'b0;
            tail    <= 1'b0;
        end else begin
            pc_f    <= pc_next;
            q_count <= count_next;
            if (redirect_valid) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (push) begin
                    tail <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
            end
        end
    end

    // Queue storage: the word on imem_instr belongs to the current pc_f
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else if (push) begin
            q_pc[tail]    <= pc_f;
            q_instr[tail] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the stimulus side predicts the contiguous PC stream
// decode must see; a negedge monitor pops and compares on every accepted instruction.
module tb_fetch_sequencer;

    localparam int unsigned N = 32;
    localparam int unsigned R = 6;

    logic         clk;
    logic         reset_n;
    logic         fetch_en;
    logic [R-1:0] imem_addr;
    logic [N-1:0] imem_instr;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         dec_valid;
    logic         dec_ready;
    logic [N-1:0] dec_instr;
    logic [N-1:0] dec_pc;
    logic [1:0]   q_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_next;
    logic [31:0] ram [64];
    int          n_checks;
    int          n_fail;
    int          n_pops;

    fetch_sequencer #(.N(N), .R(R), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .q_count        (q_count)
    );

    assign imem_instr = ram[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) % 32'd64);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Keep the expected stream topped up ahead of decode
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: exp_next, instr: word_at(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic flush(input logic [31:0] pc);
        exp_q.delete();
        exp_next = pc & ~32'd3;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        flush(pc);
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head must be the next instruction of the predicted stream
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("valid_vs_count", 32'(dec_valid), 32'(q_count != 2'd0));
            check("count_range", 32'(q_count <= 2'd2), 32'd1);
            if (dec_valid && dec_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc %h, expected no instruction", dec_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_pc", dec_pc, e.pc);
                    check("pop_instr", dec_instr, e.instr);
                end
            end
        end
    end

    initial begin
        logic [31:0] prev_pc;
        logic [R-1:0] held_addr;

        n_checks = 0;
        n_fail   = 0;
        n_pops   = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + 32'(i);
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush(32'h0);
        #2;
        check("reset_valid", 32'(dec_valid), 32'd0);
        check("reset_count", 32'(q_count), 32'd0);
        check("reset_instr", dec_instr, 32'd0);
        check("reset_pc", dec_pc, 32'd0);
        check("reset_addr", 32'(imem_addr), 32'd0);

        // Stream start: first valid two edges after release, then one per cycle
        step();
        step();
        reset_n   = 1'b1;
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        step();
        check("start_not_yet_valid", 32'(dec_valid), 32'd0);
        step();
        check("start_valid", 32'(dec_valid), 32'd1);
        check("start_pc", dec_pc, 32'h0);
        check("start_instr", dec_instr, 32'hA000_0000);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("stream_pc", dec_pc, 32'(4 * k));
            check("stream_instr", dec_instr, 32'hA000_0000 + 32'(k));
        end

        // Backpressure: queue fills, fetch address parks two words past the head
        dec_ready = 1'b0;
        prev_pc   = dec_pc;
        for (int k = 0; k < 5; k++) step();
        check("bp_count", 32'(q_count), 32'd2);
        check("bp_head_pc", dec_pc, prev_pc);
        check("bp_head_instr", dec_instr, word_at(prev_pc));
        check("bp_addr", 32'(imem_addr), ((prev_pc >> 2) + 32'd2) % 32'd64);

        // Release: pop and push together at full occupancy
        dec_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("tput_count", 32'(q_count), 32'd2);
            check("tput_pc", dec_pc, prev_pc + 32'd4);
            prev_pc = dec_pc;
        end

        // Redirect with a full queue, misaligned target
        dec_ready = 1'b0;
        step();
        redirect(32'h42);
        check("redir_count", 32'(q_count), 32'd0);
        check("redir_valid", 32'(dec_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'd16);
        dec_ready = 1'b1;
        step();
        check("redir_head_pc", dec_pc, 32'h40);
        check("redir_head_instr", dec_instr, 32'hA000_0010);

        // Memory-index wrap
        redirect(32'hF8);
        step();
        check("wrap_pc0", dec_pc, 32'hF8);
        check("wrap_instr0", dec_instr, 32'hA000_003E);
        step();
        check("wrap_pc1", dec_pc, 32'hFC);
        check("wrap_instr1", dec_instr, 32'hA000_003F);
        step();
        check("wrap_pc2", dec_pc, 32'h100);
        check("wrap_instr2", dec_instr, 32'hA000_0000);

        // PC wrap at 2**N
        redirect(32'hFFFF_FFFE);
        step();
        check("pcwrap_pc0", dec_pc, 32'hFFFF_FFFC);
        check("pcwrap_instr0", dec_instr, 32'hA000_003F);
        step();
        check("pcwrap_pc1", dec_pc, 32'h0);
        check("pcwrap_instr1", dec_instr, 32'hA000_0000);

        // fetch_en low: queue drains, PC holds
        dec_ready = 1'b0;
        step();
        step();
        fetch_en  = 1'b0;
        dec_ready = 1'b1;
        step();
        check("drain_count1", 32'(q_count), 32'd1);
        held_addr = imem_addr;
        step();
        check("drain_count0", 32'(q_count), 32'd0);
        step();
        step();
        check("drain_hold_count", 32'(q_count), 32'd0);
        check("drain_hold_addr", 32'(imem_addr), 32'(held_addr));
        fetch_en = 1'b1;

        // Randomized traffic against the stream model
        for (int k = 0; k < 400; k++) begin
            dec_ready = ($urandom_range(3) != 0);
            fetch_en  = ($urandom_range(7) != 0);
            if ($urandom_range(19) == 0) begin
                redirect($urandom());
            end else begin
                step();
            end
        end

        // Mid-stream reset with a full queue
        fetch_en  = 1'b1;
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("pre_reset_count", 32'(q_count), 32'd2);
        reset_n = 1'b0;
        flush(32'h0);
        #1;
        check("midreset_valid", 32'(dec_valid), 32'd0);
        check("midreset_count", 32'(q_count), 32'd0);
        check("midreset_addr", 32'(imem_addr), 32'd0);
        step();
        reset_n   = 1'b1;
        dec_ready = 1'b1;
        step();
        step();
        check("restart_pc", dec_pc, 32'h0);
        check("restart_instr", dec_instr, 32'hA000_0000);
        for (int k = 0; k < 6; k++) step();

        check("pop_liveness", 32'(n_pops >= 100), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
